reg_bus_arbiter: RTL and testbench

Two-master arbiter for the 8-bit register-file bus (addr/wen/wdata/ren/rdata with req/gnt handshake).
- Master 0 is typically the UART command parser; master 1 is a second bus master (e.g. a debug or DMA engine).
- Grants exclusive bus ownership with round-robin fairness and muxes the owner's bus signals to the single register-file slave port.

---
 rtl/reg_bus_arbiter.sv | 86 ++++++++
 tb/tb_reg_bus_arbiter.sv | 133 +++++++++++++
 2 files changed

// File: rtl/reg_bus_arbiter.sv
// reg_bus_arbiter: two-master round-robin arbiter and mux for the 8-bit register-file bus.
// Define REG_ARB_TIMEOUT_EN to force a handover after HOLD_MAX waiting cycles.
module reg_bus_arbiter #(
    parameter int          ADDR_W   = 8,
    parameter int          DATA_W   = 8,
    parameter logic [15:0] HOLD_MAX = 16'd256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req_i,
    output logic              m0_gnt_o,
    input  logic [ADDR_W-1:0] m0_addr_i,
    input  logic              m0_wen_i,
    input  logic [DATA_W-1:0] m0_wdata_i,
    input  logic              m0_ren_i,
    output logic [DATA_W-1:0] m0_rdata_o,
    input  logic              m1_req_i,
    output logic              m1_gnt_o,
    input  logic [ADDR_W-1:0] m1_addr_i,
    input  logic              m1_wen_i,
    input  logic [DATA_W-1:0] m1_wdata_i,
    input  logic              m1_ren_i,
    output logic [DATA_W-1:0] m1_rdata_o,
    output logic [ADDR_W-1:0] s_addr_o,
    output logic              s_wen_o,
    output logic [DATA_W-1:0] s_wdata_o,
    output logic              s_ren_o,
    input  logic [DATA_W-1:0] s_rdata_i,
    output logic              busy_o,
    output logic              owner_o,
    output logic              timeout_o
);
    typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;
    state_t state, next;
    logic last_id, own_req, oth_req, expire, g0, g1;
    assign g0 = state == OWN0;
    assign g1 = state == OWN1;
    assign own_req = (g0 & m0_req_i) | (g1 & m1_req_i);
    assign oth_req = (g0 & m1_req_i) | (g1 & m0_req_i);
`ifdef REG_ARB_TIMEOUT_EN
    logic [15:0] hold_cnt;
    logic        tmo_q;
    assign expire = own_req & oth_req & (hold_cnt == HOLD_MAX - 16'd1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_cnt <= '0;
            tmo_q    <= 1'b0;
        end else begin
            hold_cnt <= (next != state || !oth_req) ? '0 : hold_cnt + {15'd0, hold_cnt != 16'hFFFF};
            tmo_q    <= expire;
        end
    end
    assign timeout_o = tmo_q;
`else
    logic unused_hold;
    assign unused_hold = ^HOLD_MAX;
    assign expire = 1'b0;
    assign timeout_o = 1'b0;
`endif
    always_comb begin
        next = IDLE;
        if (state == IDLE)
            next = (m0_req_i & m1_req_i) ? (last_id ? OWN0 : OWN1) : m0_req_i ? OWN0 : m1_req_i ? OWN1 : IDLE;
        else
            next = (own_req & ~expire) ? state : oth_req ? (g0 ? OWN1 : OWN0) : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            last_id <= 1'b1;
        end else begin
            state   <= next;
            last_id <= next == OWN0 ? 1'b0 : next == OWN1 ? 1'b1 : last_id;
        end
    end
    assign m0_gnt_o   = g0;
    assign m1_gnt_o   = g1;
    assign busy_o     = g0 | g1;
    assign owner_o    = g1;
    assign s_addr_o   = g0 ? m0_addr_i : g1 ? m1_addr_i : '0;
    assign s_wdata_o  = g0 ? m0_wdata_i : g1 ? m1_wdata_i : '0;
    assign s_wen_o    = (g0 & m0_wen_i) | (g1 & m1_wen_i);
    assign s_ren_o    = (g0 & m0_ren_i) | (g1 & m1_ren_i);
    assign m0_rdata_o = g0 ? s_rdata_i : '0;
    assign m1_rdata_o = g1 ? s_rdata_i : '0;
endmodule

// File: tb/tb_reg_bus_arbiter.sv
// tb_reg_bus_arbiter: randomized and directed scoreboard bench for reg_bus_arbiter.
module tb_reg_bus_arbiter;
    localparam int HM = 4;
    typedef struct packed {
        logic [4:0]  hs;
        logic [17:0] bus;
        logic [15:0] rd;
    } exp_t;
    logic clk = 1'b0, rst = 1'b0;
    logic m0_req = 0, m0_wen = 0, m0_ren = 0, m1_req = 0, m1_wen = 0, m1_ren = 0;
    logic [7:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, s_rdata = 0;
    logic m0_gnt, m1_gnt, s_wen, s_ren, busy, owner, timeout;
    logic [7:0] m0_rdata, m1_rdata, s_addr, s_wdata;
    int n_chk = 0, n_fail = 0;
    int mo = -1, ml = 1, mw = 0;
    bit mt = 0;
    exp_t q[$];
    always #5 clk = ~clk;
    reg_bus_arbiter #(.ADDR_W(8), .DATA_W(8), .HOLD_MAX(16'(HM))) dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_gnt_o(m0_gnt), .m0_addr_i(m0_addr), .m0_wen_i(m0_wen),
        .m0_wdata_i(m0_wdata), .m0_ren_i(m0_ren), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_gnt_o(m1_gnt), .m1_addr_i(m1_addr), .m1_wen_i(m1_wen),
        .m1_wdata_i(m1_wdata), .m1_ren_i(m1_ren), .m1_rdata_o(m1_rdata),
        .s_addr_o(s_addr), .s_wen_o(s_wen), .s_wdata_o(s_wdata), .s_ren_o(s_ren),
        .s_rdata_i(s_rdata), .busy_o(busy), .owner_o(owner), .timeout_o(timeout)
    );
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Expected outputs for the current cycle, derived from the model's notion of who owns the bus.
    function automatic exp_t expect_now();
        exp_t e;
        e.hs = {mo == 0, mo == 1, mo >= 0, mo == 1, mt};
        e.bus = mo == 0 ? {m0_addr, m0_wen, m0_wdata, m0_ren} :
                mo == 1 ? {m1_addr, m1_wen, m1_wdata, m1_ren} : 18'd0;
        e.rd = {mo == 0 ? s_rdata : 8'd0, mo == 1 ? s_rdata : 8'd0};
        return e;
    endfunction
    task automatic model_edge();
        bit r[2];
        bit own, oth, pre;
        int nx;
        r[0] = m0_req;
        r[1] = m1_req;
        own = mo >= 0 && r[mo];
        oth = mo >= 0 && r[1-mo];
        pre = 0;
        if (mo < 0) nx = (r[0] && r[1]) ? 1 - ml : r[0] ? 0 : r[1] ? 1 : -1;
        else nx = own ? mo : oth ? 1 - mo : -1;
`ifdef REG_ARB_TIMEOUT_EN
        pre = own && oth && mw == HM - 1;
        if (pre) nx = 1 - mo;
        mw = (own && oth && !pre) ? mw + 1 : 0;
`endif
        mt = pre;
        if (nx >= 0) ml = nx;
        mo = nx;
    endtask
    task automatic step(input bit q0, input bit w0, input bit e0, input logic [7:0] a0, input logic [7:0] d0,
                        input bit q1, input bit w1, input bit e1, input logic [7:0] a1, input logic [7:0] d1,
                        input logic [7:0] rd);
        @(posedge clk);
        #1;
        {m0_req, m0_wen, m0_ren, m0_addr, m0_wdata} = {q0, w0, e0, a0, d0};
        {m1_req, m1_wen, m1_ren, m1_addr, m1_wdata} = {q1, w1, e1, a1, d1};
        s_rdata = rd;
        q.push_back(expect_now());
        model_edge();
    endtask
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("handshake{g0,g1,busy,owner,tmo}", 64'(dut.m0_gnt_o) << 4 | 64'({m1_gnt, busy, owner, timeout}), 64'(e.hs));
            chk("slave_bus", 64'({s_addr, s_wen, s_wdata, s_ren}), 64'(e.bus));
            chk("rdata{m0,m1}", 64'({m0_rdata, m1_rdata}), 64'(e.rd));
        end
    end
    initial begin
        exp_t z;
        z = '0;
        q.push_back(z);
        #12 rst = 1'b1;
        step(1, 0, 0, 8'h12, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        step(1, 0, 0, 8'h12, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        step(0, 0, 0, 8'h12, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 4; i++) step(1, 0, 0, 8'h20, 8'h00, 1, 0, 0, 8'h30, 8'h00, 8'h00);
        step(0, 0, 0, 8'h20, 8'h00, 1, 0, 0, 8'h30, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 1, 0, 8'h05, 8'h5A, 1, 1, 0, 8'h05, 8'hA5, 8'h00);
        step(1, 1, 0, 8'h05, 8'h5A, 0, 0, 0, 8'h05, 8'hA5, 8'h00);
        for (int i = 0; i < 3; i++) step(1, 0, 1, 8'h03, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h3C);
        @(posedge clk);
        #1;
        {m0_req, m0_wen, m1_req, m1_wen} = 4'b1100;
        #1;
        chk("pre_reset_s_wen", 64'(s_wen), 64'(mo == 0));
        #1 rst = 1'b0;
        #1;
        chk("async_rst_m0_gnt", 64'(m0_gnt), 64'd0);
        chk("async_rst_s_wen", 64'(s_wen), 64'd0);
        chk("async_rst_busy", 64'(busy), 64'd0);
        {m0_req, m0_wen} = 2'b00;
        {mo, ml, mw, mt} = {-32'sd1, 32'sd1, 32'sd0, 1'b0};
        #3 rst = 1'b1;
        for (int i = 0; i < 2; i++) step(1, 0, 0, 8'h40, 8'h00, 1, 0, 0, 8'h41, 8'h00, 8'h00);
        step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        step(1, 0, 0, 8'h50, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        for (int i = 0; i < 8; i++) step(1, 0, 0, 8'h50, 8'h00, 1, 0, 0, 8'h51, 8'h00, 8'h00);
        step(0, 0, 0, 8'h00, 8'h00, 0, 0, 0, 8'h00, 8'h00, 8'h00);
        begin
            bit r0, r1;
            r0 = 0;
            r1 = 0;
            for (int i = 0; i < 2000; i++) begin
                if ($urandom_range(0, 3) == 0) r0 = ~r0;
                if ($urandom_range(0, 3) == 0) r1 = ~r1;
                step(r0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                     r1, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
            end
        end
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
